// File: rtl/alu_share_arbiter.sv
// Two-requester round-robin front end for the shared ALU and its src-B mux.
// One transaction in flight: accept, one ALU cycle, then hold the response.
module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic              req0_alusrc_i,
  input  logic [DATA_W-1:0] req0_src_a_i,
  input  logic [DATA_W-1:0] req0_rd2_i,
  input  logic [DATA_W-1:0] req0_imm_ext_i,
  input  logic [CTRL_W-1:0] req0_alu_ctrl_i,
  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic              req1_alusrc_i,
  input  logic [DATA_W-1:0] req1_src_a_i,
  input  logic [DATA_W-1:0] req1_rd2_i,
  input  logic [DATA_W-1:0] req1_imm_ext_i,
  input  logic [CTRL_W-1:0] req1_alu_ctrl_i,
  output logic              alu_valid_o,
  output logic [DATA_W-1:0] alu_src_a_o,
  output logic [DATA_W-1:0] alu_src_b_o,
  output logic [CTRL_W-1:0] alu_ctrl_o,
  input  logic [DATA_W-1:0] alu_result_i,
  output logic              rsp_valid_o,
  output logic              rsp_id_o,
  output logic [DATA_W-1:0] rsp_result_o,
  input  logic              rsp_ready_i
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_last;
  logic              r_id;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [CTRL_W-1:0] r_ctrl;
  logic              r_rsp_id;
  logic [DATA_W-1:0] r_rsp_res;

  logic              w_any;
  logic              w_gnt;
  logic              w_acc;
  logic [DATA_W-1:0] w_b0;
  logic [DATA_W-1:0] w_b1;

  assign w_any = req0_valid_i | req1_valid_i;
  // Both valid: hand the grant to whoever did not win last time.
  assign w_gnt = (req0_valid_i & req1_valid_i) ? ~r_last : req1_valid_i;
  assign w_b0  = req0_alusrc_i ? req0_imm_ext_i : req0_rd2_i;
  assign w_b1  = req1_alusrc_i ? req1_imm_ext_i : req1_rd2_i;

  always_comb begin
    w_next       = r_state;
    w_acc        = 1'b0;
    req0_ready_o = 1'b0;
    req1_ready_o = 1'b0;
    alu_valid_o  = 1'b0;
    rsp_valid_o  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_any && !rst_i) begin
          w_acc        = 1'b1;
          req0_ready_o = ~w_gnt;
          req1_ready_o = w_gnt;
          w_next       = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_valid_o = ~rst_i;
        w_next      = S_RESP;
      end
      S_RESP: begin
        rsp_valid_o = ~rst_i;
        if (rsp_ready_i) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Nothing stale reaches the ALU or the consumer outside their live cycles.
  assign alu_src_a_o  = alu_valid_o ? r_a : '0;
  assign alu_src_b_o  = alu_valid_o ? r_b : '0;
  assign alu_ctrl_o   = alu_valid_o ? r_ctrl : '0;
  assign rsp_id_o     = rsp_valid_o & r_rsp_id;
  assign rsp_result_o = rsp_valid_o ? r_rsp_res : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_last    <= 1'b1;
      r_id      <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_ctrl    <= '0;
      r_rsp_id  <= 1'b0;
      r_rsp_res <= '0;
    end else begin
      r_state <= w_next;
      if (w_acc) begin
        r_id   <= w_gnt;
        r_last <= w_gnt;
        r_a    <= w_gnt ? req1_src_a_i : req0_src_a_i;
        r_b    <= w_gnt ? w_b1 : w_b0;
        r_ctrl <= w_gnt ? req1_alu_ctrl_i : req0_alu_ctrl_i;
      end
      if (r_state == S_EXEC) begin
        r_rsp_id  <= r_id;
        r_rsp_res <= alu_result_i;
      end
    end
  end

endmodule
